// File: rtl/sdram_axi_pkg.sv
// rtl/sdram_axi_pkg.sv - shared SDRAM PHY command encodings and read-latency helper
package sdram_axi_pkg;

  localparam logic [3:0] CMD_NOP      = 4'b0111;
  localparam logic [3:0] CMD_READ     = 4'b0101;
  localparam logic [3:0] CMD_WRITE    = 4'b0100;
  localparam logic [3:0] CMD_DESELECT = 4'b1111;

  // Cycles from a READ on core_cmd_i to its first beat on core_rdata_o.
  function automatic int rd_latency(input int cas_latency, input int in_stages);
    return 1 + cas_latency + in_stages;
  endfunction

  localparam int DEFAULT_READ_LATENCY = rd_latency(2, 1);

endpackage

// File: rtl/sdram_axi_phy_if.sv
// rtl/sdram_axi_phy_if.sv - core-side and pad-side signal bundle of the SDRAM PHY
interface sdram_axi_phy_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13
);
  logic                  core_cke_i;
  logic [3:0]            core_cmd_i;
  logic [DATA_W/8-1:0]   core_dqm_i;
  logic [ADDR_W-1:0]     core_addr_i;
  logic [1:0]            core_ba_i;
  logic [DATA_W-1:0]     core_wdata_i;
  logic                  core_wdata_en_i;
  logic [DATA_W-1:0]     core_rdata_o;
  logic                  sdram_clk_o;
  logic                  sdram_cke_o;
  logic [3:0]            sdram_cmd_o;
  logic [DATA_W/8-1:0]   sdram_dqm_o;
  logic [ADDR_W-1:0]     sdram_addr_o;
  logic [1:0]            sdram_ba_o;
  logic [DATA_W-1:0]     sdram_dq_o;
  logic                  sdram_dq_oe_o;
  logic [DATA_W-1:0]     sdram_dq_i;
  logic                  rd_valid_o;
  logic                  oe_conflict_o;

  modport master (
    output core_cke_i, core_cmd_i, core_dqm_i, core_addr_i, core_ba_i,
           core_wdata_i, core_wdata_en_i, sdram_dq_i,
    input  core_rdata_o, sdram_clk_o, sdram_cke_o, sdram_cmd_o, sdram_dqm_o,
           sdram_addr_o, sdram_ba_o, sdram_dq_o, sdram_dq_oe_o,
           rd_valid_o, oe_conflict_o
  );

  modport slave (
    input  core_cke_i, core_cmd_i, core_dqm_i, core_addr_i, core_ba_i,
           core_wdata_i, core_wdata_en_i, sdram_dq_i,
    output core_rdata_o, sdram_clk_o, sdram_cke_o, sdram_cmd_o, sdram_dqm_o,
           sdram_addr_o, sdram_ba_o, sdram_dq_o, sdram_dq_oe_o,
           rd_valid_o, oe_conflict_o
  );
endinterface

// File: rtl/sdram_axi_phy_rdtrack.sv
// rtl/sdram_axi_phy_rdtrack.sv - READ latency tracker: read-beat valid and DQ contention flag
module sdram_axi_phy_rdtrack
  import sdram_axi_pkg::*;
#(
  parameter int CAS_LATENCY = 2,
  parameter int IN_STAGES   = 1,
  parameter int BURST_LEN   = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cke_i,
  input  logic [3:0] cmd_i,
  input  logic       wdata_en_i,
  output logic       rd_valid_o,
  output logic       oe_conflict_o
);

  localparam int READ_LAT = rd_latency(CAS_LATENCY, IN_STAGES);
  // rd_valid_o is itself the last tracking stage, so the exit tap sits one earlier.
  localparam int EXIT_POS = READ_LAT - 2;
  // A write enabled at pipe position p drives DQ one cycle later, while the device
  // drives its beats at positions CAS_LATENCY-1 .. CAS_LATENCY+BURST_LEN-2.
  localparam int WIN_LO   = CAS_LATENCY - 1;
  localparam int WIN_HI   = CAS_LATENCY + BURST_LEN - 2;
  localparam int DEPTH    = ((WIN_HI > EXIT_POS) ? WIN_HI : EXIT_POS) + 1;

  localparam logic [DEPTH-1:0] ONES     = '1;
  localparam logic [DEPTH-1:0] WIN_MASK = (ONES >> (DEPTH - 1 - WIN_HI)) & (ONES << WIN_LO);

  logic [DEPTH-1:0] rd_pipe;
  logic [1:0]       beat_cnt;
  logic             is_read;

  assign is_read = cke_i && (cmd_i == CMD_READ);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_pipe       <= '0;
      beat_cnt      <= 2'd0;
      rd_valid_o    <= 1'b0;
      oe_conflict_o <= 1'b0;
    end else begin
      rd_pipe <= {rd_pipe[DEPTH-2:0], is_read};
      // A fresh exit always restarts the burst count rather than extending it.
      if (rd_pipe[EXIT_POS]) begin
        rd_valid_o <= 1'b1;
        beat_cnt   <= 2'(BURST_LEN - 1);
      end else if (beat_cnt != 2'd0) begin
        rd_valid_o <= 1'b1;
        beat_cnt   <= beat_cnt - 2'd1;
      end else begin
        rd_valid_o <= 1'b0;
      end
      if (wdata_en_i && (|(rd_pipe & WIN_MASK))) begin
        oe_conflict_o <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_axi_phy.sv
// rtl/sdram_axi_phy.sv - SDRAM pad I/O stage; SDRAM_PHY_NEGEDGE_CAPTURE_EN adds falling-edge DQ capture
module sdram_axi_phy
  import sdram_axi_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 13,
  parameter int CAS_LATENCY = 2,
  parameter int IN_STAGES   = 1,
  parameter int BURST_LEN   = 2
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  sdram_axi_phy_if.slave bus
);

  logic [DATA_W-1:0] cap_in;
  logic [DATA_W-1:0] cap_pipe [IN_STAGES];

  // Inverted clock puts the device sampling edge mid-cycle of the registered pins.
  assign bus.sdram_clk_o = ~clk_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.sdram_cke_o   <= 1'b0;
      bus.sdram_cmd_o   <= CMD_DESELECT;
      bus.sdram_dqm_o   <= {(DATA_W/8){1'b1}};
      bus.sdram_addr_o  <= {ADDR_W{1'b0}};
      bus.sdram_ba_o    <= 2'b00;
      bus.sdram_dq_o    <= {DATA_W{1'b0}};
      bus.sdram_dq_oe_o <= 1'b0;
    end else begin
      bus.sdram_cke_o   <= bus.core_cke_i;
      bus.sdram_cmd_o   <= bus.core_cmd_i;
      bus.sdram_dqm_o   <= bus.core_dqm_i;
      bus.sdram_addr_o  <= bus.core_addr_i;
      bus.sdram_ba_o    <= bus.core_ba_i;
      bus.sdram_dq_o    <= bus.core_wdata_i;
      bus.sdram_dq_oe_o <= bus.core_wdata_en_i;
    end
  end

`ifdef SDRAM_PHY_NEGEDGE_CAPTURE_EN
  logic [DATA_W-1:0] neg_q;

  // Half-cycle earlier sample of the pad; the first posedge stage re-times it.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      neg_q <= {DATA_W{1'b0}};
    end else begin
      neg_q <= bus.sdram_dq_i;
    end
  end

  assign cap_in = neg_q;
`else
  assign cap_in = bus.sdram_dq_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < IN_STAGES; i++) begin
        cap_pipe[i] <= {DATA_W{1'b0}};
      end
    end else begin
      cap_pipe[0] <= cap_in;
      for (int i = 1; i < IN_STAGES; i++) begin
        cap_pipe[i] <= cap_pipe[i-1];
      end
    end
  end

  assign bus.core_rdata_o = cap_pipe[IN_STAGES-1];

  sdram_axi_phy_rdtrack #(
    .CAS_LATENCY (CAS_LATENCY),
    .IN_STAGES   (IN_STAGES),
    .BURST_LEN   (BURST_LEN)
  ) u_rdtrack (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .cke_i         (bus.core_cke_i),
    .cmd_i         (bus.core_cmd_i),
    .wdata_en_i    (bus.core_wdata_en_i),
    .rd_valid_o    (bus.rd_valid_o),
    .oe_conflict_o (bus.oe_conflict_o)
  );

endmodule

// File: tb/tb_sdram_axi_phy.sv
// tb/tb_sdram_axi_phy.sv - self-checking bench for sdram_axi_phy against a cycle-history reference model
module tb_sdram_axi_phy;
  import sdram_axi_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 13;
  localparam int CAS    = 2;
  localparam int INS    = 1;
  localparam int BL     = 2;
  localparam int L      = rd_latency(CAS, INS);
  localparam int MAXC   = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdram_axi_phy_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  sdram_axi_phy #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CAS_LATENCY(CAS), .IN_STAGES(INS), .BURST_LEN(BL)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // Per-cycle record of everything driven into the DUT.
  logic        h_rst   [MAXC];
  logic        h_cke   [MAXC];
  logic [3:0]  h_cmd   [MAXC];
  logic [1:0]  h_dqm   [MAXC];
  logic [12:0] h_addr  [MAXC];
  logic [1:0]  h_ba    [MAXC];
  logic [15:0] h_wdata [MAXC];
  logic        h_wen   [MAXC];
  logic [15:0] h_dq    [MAXC];

  logic        n_rst, n_cke, n_wen;
  logic [3:0]  n_cmd;
  logic [1:0]  n_dqm, n_ba;
  logic [12:0] n_addr;
  logic [15:0] n_wdata, n_dq;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  task automatic set_idle();
    n_rst   = 1'b1;
    n_cke   = 1'b1;
    n_cmd   = CMD_NOP;
    n_dqm   = 2'($urandom);
    n_addr  = 13'($urandom);
    n_ba    = 2'($urandom);
    n_wdata = 16'($urandom);
    n_wen   = 1'b0;
    n_dq    = 16'($urandom);
  endtask

  // Drive one cycle's inputs just after the edge, then return at the falling edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    rst_n               = n_rst;
    bus.core_cke_i      = n_cke;
    bus.core_cmd_i      = n_cmd;
    bus.core_dqm_i      = n_dqm;
    bus.core_addr_i     = n_addr;
    bus.core_ba_i       = n_ba;
    bus.core_wdata_i    = n_wdata;
    bus.core_wdata_en_i = n_wen;
    bus.sdram_dq_i      = n_dq;
    h_rst[cyc] = n_rst;  h_cke[cyc] = n_cke;  h_cmd[cyc] = n_cmd;  h_dqm[cyc] = n_dqm;
    h_addr[cyc] = n_addr; h_ba[cyc] = n_ba;   h_wdata[cyc] = n_wdata;
    h_wen[cyc] = n_wen;  h_dq[cyc] = n_dq;
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_idle();
    n_rst = 1'b0;
    cycle();
    cycle();
  endtask

  function automatic bit alive(input int a, input int b);
    if (a < 1) return 1'b0;
    for (int j = a; j <= b; j++) if (!h_rst[j]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit is_rd(input int c);
    return h_cke[c] && (h_cmd[c] == CMD_READ);
  endfunction

  // Valid if some surviving READ surfaced within the last BL cycles.
  function automatic bit exp_valid(input int t);
    for (int d = 0; d < BL; d++) begin
      if ((t - L - d) >= 1 && is_rd(t - L - d) && alive(t - L - d, t)) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Write enabled at w drives DQ at w+1; device drives READ c's beats at c+1+CAS .. c+CAS+BL.
  function automatic bit exp_conflict(input int t);
    if (!h_rst[t]) return 1'b0;
    for (int w = t - 1; w >= 1; w--) begin
      if (!h_rst[w]) break;
      if (h_wen[w]) begin
        for (int k = 0; k < BL; k++) begin
          if ((w - CAS - k) >= 1 && is_rd(w - CAS - k) && alive(w - CAS - k, w)) return 1'b1;
        end
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [38:0] exp_out(input int t);
    if (!h_rst[t] || !h_rst[t-1]) return {1'b0, CMD_DESELECT, 2'b11, 13'h0, 2'b00, 16'h0, 1'b0};
    return {h_cke[t-1], h_cmd[t-1], h_dqm[t-1], h_addr[t-1], h_ba[t-1], h_wdata[t-1], h_wen[t-1]};
  endfunction

  function automatic logic [38:0] got_out();
    return {bus.sdram_cke_o, bus.sdram_cmd_o, bus.sdram_dqm_o, bus.sdram_addr_o,
            bus.sdram_ba_o, bus.sdram_dq_o, bus.sdram_dq_oe_o};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      set_idle();
      n_rst = 1'b0;
      n_cmd = 4'($urandom);
      n_cke = 1'($urandom);
      n_wen = 1'($urandom);
      cycle();
      n_checks++;
      if (got_out() !== {1'b0, 4'b1111, 2'b11, 13'h0, 2'b00, 16'h0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_outputs: got %h expected %h", got_out(),
                 {1'b0, 4'b1111, 2'b11, 13'h0, 2'b00, 16'h0, 1'b0});
      end
      n_checks++;
      if ({bus.core_rdata_o, bus.rd_valid_o, bus.oe_conflict_o} !== 18'h0) begin
        n_fail++;
        $display("FAIL reset_rd_side: got rdata=%h valid=%b conflict=%b expected 0",
                 bus.core_rdata_o, bus.rd_valid_o, bus.oe_conflict_o);
      end
    end
    n_checks++;
    if (bus.sdram_clk_o !== 1'b1) begin
      n_fail++;
      $display("FAIL sdram_clk_inverted: got %b expected 1 while clk low", bus.sdram_clk_o);
    end
    for (int i = 0; i < 8; i++) begin
      set_idle();
      n_cmd = 4'($urandom);
      n_wen = 1'($urandom);
      cycle();
      n_checks++;
      if (got_out() !== exp_out(cyc)) begin
        n_fail++;
        $display("FAIL release_track cyc %0d: got %h expected %h", cyc, got_out(), exp_out(cyc));
      end
    end
  endtask

  task automatic test_write();
    do_reset();
    for (int k = 0; k <= 8; k++) begin
      set_idle();
      if (k == 5) begin
        n_cmd   = CMD_WRITE;
        n_wdata = 16'h1234;
        n_wen   = 1'b1;
      end
      cycle();
      if (k == 6) begin
        n_checks++;
        if ({bus.sdram_cmd_o, bus.sdram_dq_o, bus.sdram_dq_oe_o} !== {4'b0100, 16'h1234, 1'b1}) begin
          n_fail++;
          $display("FAIL write_path: got cmd=%b dq=%h oe=%b expected cmd=0100 dq=1234 oe=1",
                   bus.sdram_cmd_o, bus.sdram_dq_o, bus.sdram_dq_oe_o);
        end
      end
      if (k == 7) begin
        n_checks++;
        if (bus.sdram_dq_oe_o !== 1'b0 || bus.sdram_cmd_o !== CMD_NOP) begin
          n_fail++;
          $display("FAIL write_release: got oe=%b cmd=%b expected oe=0 cmd=0111",
                   bus.sdram_dq_oe_o, bus.sdram_cmd_o);
        end
      end
    end
  endtask

  task automatic test_single_read();
    do_reset();
    for (int k = 0; k <= 20; k++) begin
      set_idle();
      if (k == 10) n_cmd = CMD_READ;
      if (k == 13) n_dq = 16'hA5A5;
      if (k == 14) n_dq = 16'h5A5A;
      cycle();
      n_checks++;
      if (bus.rd_valid_o !== ((k == 14) || (k == 15))) begin
        n_fail++;
        $display("FAIL single_read_valid k=%0d: got %b expected %b", k, bus.rd_valid_o,
                 (k == 14) || (k == 15));
      end
      if (k == 14 || k == 15) begin
        n_checks++;
        if (bus.core_rdata_o !== ((k == 14) ? 16'hA5A5 : 16'h5A5A)) begin
          n_fail++;
          $display("FAIL single_read_data k=%0d: got %h expected %h", k, bus.core_rdata_o,
                   (k == 14) ? 16'hA5A5 : 16'h5A5A);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k <= 20; k++) begin
      set_idle();
      if (k == 10 || k == 12) n_cmd = CMD_READ;
      cycle();
      n_checks++;
      if (bus.rd_valid_o !== (k >= 14 && k <= 17)) begin
        n_fail++;
        $display("FAIL back_to_back_valid k=%0d: got %b expected %b", k, bus.rd_valid_o,
                 (k >= 14 && k <= 17));
      end
    end
  endtask

  task automatic test_contention();
    do_reset();
    // Writes just outside the device-drive window must not flag.
    for (int k = 0; k <= 18; k++) begin
      set_idle();
      if (k == 10) n_cmd = CMD_READ;
      if (k == 11 || k == 14) n_wen = 1'b1;
      cycle();
      n_checks++;
      if (bus.oe_conflict_o !== 1'b0) begin
        n_fail++;
        $display("FAIL contention_edge k=%0d: got %b expected 0", k, bus.oe_conflict_o);
      end
    end
    do_reset();
    for (int k = 0; k <= 20; k++) begin
      set_idle();
      if (k == 10) n_cmd = CMD_READ;
      if (k == 12) n_wen = 1'b1;
      cycle();
      n_checks++;
      if (bus.oe_conflict_o !== (k >= 13)) begin
        n_fail++;
        $display("FAIL contention_sticky k=%0d: got %b expected %b", k, bus.oe_conflict_o, k >= 13);
      end
      if (k == 13) begin
        n_checks++;
        if (bus.sdram_dq_oe_o !== 1'b1) begin
          n_fail++;
          $display("FAIL contention_drive k=%0d: got oe=%b expected 1", k, bus.sdram_dq_oe_o);
        end
      end
    end
    set_idle();
    n_rst = 1'b0;
    cycle();
    n_checks++;
    if (bus.oe_conflict_o !== 1'b0) begin
      n_fail++;
      $display("FAIL contention_clear: got %b expected 0", bus.oe_conflict_o);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int k = 0; k <= 20; k++) begin
      set_idle();
      if (k == 10) n_cmd = CMD_READ;
      if (k == 12 || k == 13) n_rst = 1'b0;
      cycle();
      n_checks++;
      if (bus.rd_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_burst k=%0d: got %b expected 0", k, bus.rd_valid_o);
      end
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      set_idle();
      r = $urandom_range(0, 99);
      n_cmd = (r < 25) ? CMD_READ : (r < 35) ? CMD_WRITE : (r < 40) ? 4'($urandom) : CMD_NOP;
      n_wen = ($urandom_range(0, 99) < 6);
      n_cke = ($urandom_range(0, 9) != 0);
      n_rst = ($urandom_range(0, 199) != 0);
      cycle();
      n_checks++;
      if (got_out() !== exp_out(cyc)) begin
        n_fail++;
        $display("FAIL rand_outputs cyc %0d: got %h expected %h", cyc, got_out(), exp_out(cyc));
      end
      n_checks++;
      if (bus.rd_valid_o !== exp_valid(cyc)) begin
        n_fail++;
        $display("FAIL rand_rd_valid cyc %0d: got %b expected %b", cyc, bus.rd_valid_o, exp_valid(cyc));
      end
      n_checks++;
      if (bus.oe_conflict_o !== exp_conflict(cyc)) begin
        n_fail++;
        $display("FAIL rand_conflict cyc %0d: got %b expected %b", cyc, bus.oe_conflict_o,
                 exp_conflict(cyc));
      end
      if (alive(cyc - INS, cyc)) begin
        n_checks++;
        if (bus.core_rdata_o !== h_dq[cyc-INS]) begin
          n_fail++;
          $display("FAIL rand_rdata cyc %0d: got %h expected %h", cyc, bus.core_rdata_o, h_dq[cyc-INS]);
        end
      end
    end
  endtask

  initial begin
    h_rst[0] = 1'b0;
    set_idle();
    n_rst = 1'b0;
    test_reset();
    test_write();
    test_single_read();
    test_back_to_back();
    test_contention();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
